// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  BE_WORD = 4'b1111;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STAT_W  = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram_array.sv
// Word-addressed RAM: synchronous byte-enable write, combinational read.
module dmem_ram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed LATENCY.
// Optional access statistics are enabled with `define DMEM_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_loads,
  output logic [STAT_W-1:0]  stat_stores,
  output logic [STAT_W-1:0]  stat_errs
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam bit          LAT1 = (LATENCY == 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic               w_accept;
  logic               w_access;
  logic               w_acc_we;
  logic               w_acc_err;
  logic [31:0]        w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic [3:0]         w_acc_be;
  logic [31:0]        w_ram_rdata;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

  // Access operands come straight from the bus only when LATENCY==1 (access on acceptance edge).
  assign w_acc_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
  assign w_acc_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
  assign w_acc_be    = (r_state == ST_IDLE) ? bus.req_be    : r_be;
  assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) ||
                       (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = CNT_W'(LATENCY - 1);
          if (LAT1) begin
            w_access    = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_access) begin
        r_err   <= w_acc_err;
        r_rdata <= (!w_acc_we && !w_acc_err) ? w_ram_rdata : '0;
      end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  dmem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_access && w_acc_we && !w_acc_err),
    .i_addr  (w_acc_addr[AW+1:2]),
    .i_be    (w_acc_be),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] r_stat_loads, r_stat_stores, r_stat_errs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errs   <= '0;
    end else if (w_access) begin
      if (w_acc_err)     r_stat_errs   <= sat_inc(r_stat_errs);
      else if (w_acc_we) r_stat_stores <= sat_inc(r_stat_stores);
      else               r_stat_loads  <= sat_inc(r_stat_loads);
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned WIN   = 64;
  localparam logic [31:0] DECOY_ADDR = 32'h14;

  logic clk;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [31:0] mdl [WIN];
  int unsigned e_loads, e_stores, e_errs;

  dmem_responder_if bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) u_dut (
    .clk   (clk),
    .rst   (rst_n),
    .bus   (bus)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One full transaction; expectation derived from the word-array model before driving.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int unsigned hold, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    int unsigned wi;
    int unsigned cyc;
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    exp_rd  = '0;
    wi      = addr >> 2;
    if (exp_err) e_errs = sat(e_errs);
    else if (we) e_stores = sat(e_stores);
    else e_loads = sat(e_loads);
    if (!exp_err) begin
      if (we) begin
        mask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
        mdl[wi] = (mdl[wi] & ~mask) | (wdata & mask);
      end else begin
        exp_rd = mdl[wi];
      end
    end

    cyc = 0;
    while (!bus.req_ready && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 64) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency", cyc, LAT);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    got = bus.rsp_rdata;

    for (int unsigned h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = DECOY_ADDR;
      bus.req_wdata = 32'hBAD0BAD0;
      bus.req_be    = BE_WORD;
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, exp_rd);
      check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_rdata", bus.rsp_rdata, 32'd0);
    check("idle_err", 32'(bus.rsp_err), 32'd0);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int unsigned r;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    e_loads = 0; e_stores = 0; e_errs = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: store then load, latency checked inside xact
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    check("t1_store_rdata", got, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    check("t1_load", got, 32'hDEADBEEF);

    // Fill model window so every later load has a known value
    for (int unsigned w = 0; w < WIN; w++) xact(1'b1, 32'(w * 4), $urandom, BE_WORD, 0, got);

    // Test 2: partial-lane store
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, got);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, got);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("t2_merge", got, 32'h11BB33DD);

    // Test 3: error accesses leave RAM untouched
    xact(1'b0, 32'h22, 32'h0, 4'h0, 0, got);
    xact(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, got);
    xact(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, got);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("t3_unchanged", got, 32'h11BB33DD);

    // Test 4: backpressure with a decoy request while in RESP
    xact(1'b0, 32'h10, 32'h0, 4'h0, 5, got);
    xact(1'b0, DECOY_ADDR, 32'h0, 4'h0, 0, got);

    // Randomized mix
    for (int unsigned n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, WIN - 1) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = (($urandom_range(0, 1) == 0) ? 32'(4 * DEPTH + 4 * $urandom_range(0, 1000))
                                                         : 32'hFFFF_FFFC);
      else             a = 32'($urandom_range(0, WIN - 1) * 4);
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), got);
    end

    // Test 5: reset during WAIT aborts the store
    xact(1'b1, 32'h30, 32'h0, 4'hF, 0, got);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h12345678;
    bus.req_be    = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_in_wait", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    e_loads = 0; e_stores = 0; e_errs = 0;
    @(negedge clk);
    xact(1'b0, 32'h30, 32'h0, 4'h0, 0, got);
    check("t5_unwritten", got, 32'h0);

`ifdef DMEM_STATS_EN
    // Test 6: statistics counters
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e_loads = 0; e_stores = 0; e_errs = 0;
    @(negedge clk);
    check("t6_rst_loads", 32'(stat_loads), 32'd0);
    for (int unsigned k = 0; k < 3; k++) xact(1'b0, 32'(k * 4), 32'h0, 4'h0, 0, got);
    for (int unsigned k = 0; k < 2; k++) xact(1'b1, 32'(k * 4), $urandom, 4'hF, 0, got);
    xact(1'b1, 32'h41, 32'h0, 4'hF, 0, got);
    check("t6_loads", 32'(stat_loads), 32'(e_loads));
    check("t6_stores", 32'(stat_stores), 32'(e_stores));
    check("t6_errs", 32'(stat_errs), 32'(e_errs));
    check("t6_loads_abs", 32'(stat_loads), 32'd3);
    check("t6_stores_abs", 32'(stat_stores), 32'd2);
    check("t6_errs_abs", 32'(stat_errs), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_clr_loads", 32'(stat_loads), 32'd0);
    check("t6_clr_stores", 32'(stat_stores), 32'd0);
    check("t6_clr_errs", 32'(stat_errs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
